// File: rtl/adder_pkg.sv
// Shared FSM encoding and default geometry for the slice-serial adder.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ADDER_WIDTH_DEF = 16;
   localparam int ADDER_SLICE_DEF = 4;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder with carry in/out; zero latency, no flow control.
module adder_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             carry_in,
   output logic [SLICE-1:0] sum,
   output logic             carry_out
);

   logic [SLICE:0] full;

   always_comb begin
      full      = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, carry_in};
      sum       = full[SLICE-1:0];
      carry_out = full[SLICE];
   end

endmodule

// File: rtl/adder_nbit_serial.sv
// Adds WIDTH-bit operands SLICE bits per cycle; done pulses NSLICE cycles after accept.
// start is ignored while busy; ADDER_SIGNED_OVF_EN adds a signed_ovf output.
module adder_nbit_serial
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEF,
   parameter int SLICE = ADDER_SLICE_DEF
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
`ifdef ADDER_SIGNED_OVF_EN
   ,
   output logic             signed_ovf
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if (WIDTH % SLICE != 0) begin : g_bad_geometry
      $error("adder_nbit_serial: WIDTH must be a multiple of SLICE");
   end

   state_t             state_q, state_d;
   logic [KW-1:0]      k_q, k_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic               ovf_q, ovf_d;
   logic [SLICE-1:0]   a_sl, b_sl, s_sl;
   logic               co_sl;
   logic               accept, last;

   assign accept = start && ((state_q == IDLE) || (state_q == DONE));
   assign last   = (k_q == KW'(NSLICE - 1));

   // Mux the active operand slice with constant part-selects.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (k_q == KW'(i)) begin
            a_sl = a_q[i*SLICE +: SLICE];
            b_sl = b_q[i*SLICE +: SLICE];
         end
      end
   end

   adder_slice #(.SLICE(SLICE)) u_slice (
      .a         (a_sl),
      .b         (b_sl),
      .carry_in  (carry_q),
      .sum       (s_sl),
      .carry_out (co_sl)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q == RUN);
      done     = (state_q == DONE);
      sum      = sum_q;
      overflow = ovf_q;
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_d     = a;
         b_d     = b;
         carry_d = carry_in;
         k_d     = '0;
      end else if (state_q == RUN) begin
         for (int i = 0; i < NSLICE; i++) begin
            if (k_q == KW'(i)) sum_d[i*SLICE +: SLICE] = s_sl;
         end
         carry_d = co_sl;
         k_d     = k_q + 1'b1;
         if (last) ovf_d = co_sl;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef ADDER_SIGNED_OVF_EN
   logic sovf_q, sovf_d;

   // The last slice carries the MSB, so its sum bit is the result sign.
   always_comb begin
      sovf_d = sovf_q;
      if ((state_q == RUN) && last && !accept)
         sovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sl[SLICE-1] != a_q[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) sovf_q <= 1'b0;
      else        sovf_q <= sovf_d;
   end

   assign signed_ovf = sovf_q;
`endif

endmodule

// File: doc/adder_nbit_serial.md
ADDER_NBIT_SERIAL -- requirements
Module: adder_nbit_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of SLICE, with NSLICE = WIDTH/SLICE.
REQ-003 The block SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 The block SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-006 The block SHALL have port a  input  WIDTH  first operand; captured on accept.
REQ-007 The block SHALL have port b  input  WIDTH  second operand; captured on accept.
REQ-008 The block SHALL have port carry_in  input  1  carry into the LSB slice; captured on accept.
REQ-009 The block SHALL have port busy  output  1  high while slices are being computed.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port sum  output  WIDTH  result bits WIDTH-1:0 of a+b+carry_in.
REQ-012 The block SHALL have port overflow  output  1  unsigned carry out of the MSB.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 Accept SHALL occur on a clk edge where start=1 and the state is IDLE or DONE; a, b and carry_in SHALL then be registered, the slice index SHALL be cleared to 0, and the state SHALL go to RUN.
REQ-015 In RUN, each clk edge SHALL add operand slice k of a, slice k of b and the carry register, with slice 0 at the LSB.
REQ-016 The result of each RUN edge SHALL be written to sum[k*SLICE +: SLICE], the slice carry-out SHALL go to the carry register, and k SHALL increment.
REQ-017 When the edge processing k = NSLICE-1 occurs, the state SHALL go to DONE and overflow SHALL take the final carry.
REQ-018 With accept at edge T, done SHALL be high exactly during the cycle after edge T+NSLICE (latency NSLICE cycles).
REQ-019 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE).
REQ-020 DONE SHALL return to IDLE on the next edge unless start=1, in which case back-to-back accept SHALL apply with no idle cycle.
REQ-021 start while in RUN SHALL be ignored; captured operands SHALL be unaffected by input changes after accept.
REQ-022 sum and overflow SHALL hold the last completed result from DONE until the next accept, and SHALL be undefined-but-stable only during RUN.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH; the slice adder SHALL be SLICE+1 bits wide internally.

Reset
REQ-024 Asserting n_rst=0 at any time, including mid-RUN, SHALL asynchronously force state=IDLE, busy=0, done=0, sum=0, overflow=0, k=0, carry register=0 and operand registers=0.
REQ-025 After n_rst deasserts, the first accept SHALL be possible on the first rising edge of clk.

Configuration
REQ-026 With macro ADDER_SIGNED_OVF_EN defined, the block SHALL add port signed_ovf  output  1, set on the DONE transition to (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), reset to 0, and held with sum.
REQ-027 Without ADDER_SIGNED_OVF_EN, the signed_ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package adder_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default WIDTH and SLICE constants.
REQ-029 A combinational sub-module adder_slice, parametrised by SLICE, SHALL compute {carry_out, sum} = a + b + carry_in and SHALL be instantiated once.
REQ-030 A static elaboration check SHALL fail when WIDTH % SLICE != 0.

Verification (WIDTH=16, SLICE=4)
REQ-031 Test: a=0xFFFF, b=0x0001, carry_in=0, start pulse -> busy for 4 cycles, then done pulse with sum=0x0000 and overflow=1.
REQ-032 Test: a=0x1234, b=0x4321, carry_in=1 -> done 4 cycles after accept with sum=0x5556 and overflow=0.
REQ-033 Test: start reasserted with a=0x0000 during RUN of 0x00FF+0x0001 -> ignored; result sum=0x0100 and only one done pulse.
REQ-034 Test: n_rst pulled low 2 cycles into RUN -> all outputs 0 immediately; no done pulse; a fresh 0x0002+0x0003 then yields sum=0x0005.
REQ-035 Test: start held high through DONE -> back-to-back accept; two done pulses 5 cycles apart; each result correct.
REQ-036 Test, with ADDER_SIGNED_OVF_EN: 0x7FFF+0x0001 -> signed_ovf=1 and overflow=0; 0xFFFF+0x0001 -> signed_ovf=0 and overflow=1.
